serial_to_parallel_rx: RTL and testbench
========================================

// Module: serial_to_parallel_rx
// PURPOSE
//   Receive-side partner of the parallel-to-serial transmitter. Consumes its MSB-first
//   serial bit stream on the fast bit clock, finds byte alignment from COM (0xBC)
//   symbols and locks after N_COM consecutive aligned COMs. Once locked, it rebuilds
//   each byte and presents it, with a valid flag, to the byte-rate logic downstream.
// PARAMETERS
//   WIDTH  8      bits per symbol (bit clock = WIDTH x byte clock)
//   COM    8'hBC  idle/alignment symbol sent by the transmitter when it has no valid data
//   N_COM  4      consecutive aligned COMs needed to lock (>=1)
// PORTS
//   clk_SP        input   1      bit-rate clock; all logic is rising-edge
//   reset         input   1      asynchronous, active-high reset
//   data_in_SP    input   1      serial data, MSB first, one bit per clk_SP
//   data_out_SP   output  WIDTH  last received non-COM byte
//   valid_out_SP  output  1      data_out_SP holds a data byte (not idle)
//   byte_stb_SP   output  1      one-cycle pulse when data_out_SP/valid_out_SP update
//   active_SP     output  1      receiver is locked (state ACTIVE)
// BEHAVIOUR
//   - Reset (async, immediate): state=SEARCH, shift reg=0, bit_cnt=0, com_cnt=0,
//     data_out_SP=0, valid_out_SP=0, byte_stb_SP=0, active_SP=0.
//   - Shift reg: sr <= {sr[WIDTH-2:0], data_in_SP} on every edge. The current
//     window is win = {sr[WIDTH-2:0], data_in_SP}, which includes the bit being sampled.
//   - bit_cnt counts 0..WIDTH-1 and wraps. A boundary is bit_cnt==WIDTH-1; win is the byte.
//   - FSM (next-state logic is evaluated at the clock edge):
//     SEARCH: bit_cnt is ignored. If win==COM, set bit_cnt<=0, com_cnt<=1, go SYNC.
//             If N_COM==1, go straight to ACTIVE instead.
//     SYNC:   at a boundary, if win==COM, com_cnt++. When com_cnt+1==N_COM, go ACTIVE.
//             At a boundary with win!=COM: com_cnt<=0, go SEARCH. A COM mid-byte is ignored.
//     ACTIVE: at a boundary, byte_stb_SP<=1. If win!=COM: data_out_SP<=win and
//             valid_out_SP<=1. If win==COM: valid_out_SP<=0 and data_out_SP holds.
//             ACTIVE is left only by reset. There is no realignment while locked.
//   - active_SP is registered. It rises on the edge that samples the last bit of the
//     N_COM-th COM.
//   - Latency: the last bit of a byte is sampled at edge t. data_out_SP, valid_out_SP
//     and byte_stb_SP are valid after edge t. data and valid then hold for WIDTH cycles.
//     byte_stb_SP is high for exactly that one cycle.
//   - Outside ACTIVE: valid_out_SP=0, byte_stb_SP=0, data_out_SP holds 0.
//   - Reset mid-byte or mid-lock: everything clears at once. Relock needs N_COM fresh COMs.
//   - No bit-slip detection. A misaligned link after lock is a system error that reset must clear.
// TESTING
//   1 Assert reset between edges while ACTIVE, data_out_SP=8'hAB
//     -> all outputs 0 immediately, with no clk_SP edge needed.
//   2 After reset, send BC x4 aligned to clk_SP
//     -> active_SP=1 after edge 32. valid_out_SP=0. byte_stb_SP pulses on edge 32.
//   3 Locked, then send AB, 56, BC, 01
//     -> data_out_SP=AB/valid=1 after edge 8 of AB, held 8 cycles. Then 56/1.
//     -> On BC: 56/0. Then 01/1. Each byte gives exactly one stb.
//   4 Send BC, BC, BC, 12
//     -> FSM returns to SEARCH at the 12 boundary. active_SP stays 0.
//     -> A further BC x4 then locks.
//   5 Send 3 junk bits 101, then BC x4
//     -> alignment taken from the first BC window. active_SP=1 after the 35th bit.
//   6 N_COM=1 build, send one BC
//     -> active_SP=1 after its 8th bit. The following byte 0xEF appears with valid=1.

Source files
------------

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver. Takes an MSB-first bit stream, aligns to COM
// symbols, locks after N_COM aligned COMs and presents each received byte.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_SEARCH | hunting for a COM in any bit position; bit_cnt not trusted
// ST_SYNC   | aligned on a COM, counting consecutive COMs at byte boundaries
// ST_ACTIVE | locked; every boundary produces a strobe (data or idle)
module serial_to_parallel_rx #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COM   = 8'hBC,
  parameter int               N_COM = 4
) (
  input  logic             clk_SP,
  input  logic             reset,
  input  logic             data_in_SP,
  output logic [WIDTH-1:0] data_out_SP,
  output logic             valid_out_SP,
  output logic             byte_stb_SP,
  output logic             active_SP
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NW = $clog2(N_COM + 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NW-1:0]    com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             stb_q, stb_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] win;
  logic             boundary;
  logic             is_com;
  logic             lock_reached;

  // Window includes the bit being sampled on this edge.
  assign win          = {sr_q[WIDTH-2:0], data_in_SP};
  assign is_com       = (win == COM);
  assign boundary     = (bit_cnt_q == CW'(WIDTH - 1));
  assign lock_reached = ((32'(com_cnt_q) + 32'd1) == 32'(N_COM));

  // Next-state logic for alignment FSM, counters and output registers.
  always_comb begin
    state_d   = state_q;
    sr_d      = win;
    bit_cnt_d = boundary ? '0 : bit_cnt_q + CW'(1);
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    stb_d     = 1'b0;
    active_d  = active_q;

    case (state_q)
      ST_SEARCH: begin
        if (is_com) begin
          // The COM just completed fixes the byte grid: next bit is bit 0.
          bit_cnt_d = '0;
          com_cnt_d = NW'(1);
          if (N_COM == 1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
            stb_d    = 1'b1;
            valid_d  = 1'b0;
          end else begin
            state_d = ST_SYNC;
          end
        end
      end

      ST_SYNC: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + NW'(1);
            if (lock_reached) begin
              // The locking COM is itself reported as an idle byte.
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
              stb_d    = 1'b1;
              valid_d  = 1'b0;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        if (boundary) begin
          stb_d = 1'b1;
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = win;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_SEARCH;
        com_cnt_d = '0;
        active_d  = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_SP or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
      active_q  <= active_d;
    end
  end

  assign data_out_SP  = data_q;
  assign valid_out_SP = valid_q;
  assign byte_stb_SP  = stb_q;
  assign active_SP    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: an N_COM=4 instance checked through a
// byte scoreboard plus inline checks, and an N_COM=1 instance.
module tb_serial_to_parallel_rx;

  logic       clk;
  logic       reset, reset1;
  logic       din;
  logic [7:0] dout, dout1;
  logic       valid, valid1;
  logic       stb, stb1;
  logic       active, active1;

  int tests_run = 0;
  int fails = 0;

  logic [8:0] sb[$];     // {valid, data} expected at each strobe
  logic [7:0] last_data; // model of data_out for idle bytes

  serial_to_parallel_rx #(.WIDTH(8), .COM(8'hBC), .N_COM(4)) dut (
    .clk_SP(clk), .reset(reset), .data_in_SP(din),
    .data_out_SP(dout), .valid_out_SP(valid),
    .byte_stb_SP(stb), .active_SP(active)
  );

  serial_to_parallel_rx #(.WIDTH(8), .COM(8'hBC), .N_COM(1)) dut1 (
    .clk_SP(clk), .reset(reset1), .data_in_SP(din),
    .data_out_SP(dout1), .valid_out_SP(valid1),
    .byte_stb_SP(stb1), .active_SP(active1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every strobe of the N_COM=4 receiver must match the next expected byte.
  always @(posedge clk) begin
    #1;
    if (stb === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_stb: got data=%h valid=%b, no byte expected", dout, valid);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({valid, dout} !== e)
          begin
            fails++;
            $display("FAIL sb_byte: got valid=%b data=%h, expected valid=%b data=%h",
                     valid, dout, e[8], e[7:0]);
          end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic push_data(input logic [7:0] v);
    if (v == 8'hBC) sb.push_back({1'b0, last_data});
    else begin
      sb.push_back({1'b1, v});
      last_data = v;
    end
  endtask

  // Send BC x4 from SEARCH; active must rise exactly on bit 32, with an idle strobe.
  task automatic lock4(input string name);
    logic [7:0] c;
    c = 8'hBC;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) sb.push_back({1'b0, last_data});
      send_bit(c[7 - (i % 8)]);
      tests_run++;
      if (active !== (i == 31)) begin
        fails++;
        $display("FAIL %s_active bit %0d: got %b expected %b", name, i + 1, active, (i == 31));
      end
    end
    tests_run++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_valid: got %b expected 0", name, valid);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_data = 8'h00;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({dout, valid, stb, active} !== 11'b0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h valid=%b stb=%b active=%b, expected all 0",
               dout, valid, stb, active);
    end
    tests_run++;
    if ({dout1, valid1, stb1, active1} !== 11'b0) begin
      fails++;
      $display("FAIL reset_outputs1: got data=%h valid=%b stb=%b active=%b, expected all 0",
               dout1, valid1, stb1, active1);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock();
    lock4("lock");
  endtask

  task automatic test_data();
    push_data(8'hAB);
    send_byte(8'hAB);
    tests_run++;
    if ({valid, dout} !== {1'b1, 8'hAB}) begin
      fails++;
      $display("FAIL data_ab: got valid=%b data=%h expected 1/ab", valid, dout);
    end
    push_data(8'h56);
    for (int i = 7; i >= 1; i--) begin
      send_bit(1'(8'h56 >> i));
      tests_run++;
      if ({valid, dout} !== {1'b1, 8'hAB}) begin
        fails++;
        $display("FAIL data_hold: got valid=%b data=%h expected 1/ab", valid, dout);
      end
    end
    send_bit(1'b0);
    tests_run++;
    if ({valid, dout} !== {1'b1, 8'h56}) begin
      fails++;
      $display("FAIL data_56: got valid=%b data=%h expected 1/56", valid, dout);
    end
    push_data(8'hBC);
    send_byte(8'hBC);
    tests_run++;
    if ({valid, dout} !== {1'b0, 8'h56}) begin
      fails++;
      $display("FAIL data_idle: got valid=%b data=%h expected 0/56", valid, dout);
    end
    push_data(8'h01);
    send_byte(8'h01);
    tests_run++;
    if ({valid, dout, active} !== {1'b1, 8'h01, 1'b1}) begin
      fails++;
      $display("FAIL data_01: got valid=%b data=%h active=%b expected 1/01/1", valid, dout, active);
    end
  endtask

  task automatic test_async_reset();
    push_data(8'hAB);
    send_byte(8'hAB);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({dout, valid, stb, active} !== 11'b0) begin
      fails++;
      $display("FAIL async_reset: got data=%h valid=%b stb=%b active=%b, expected all 0",
               dout, valid, stb, active);
    end
    @(negedge clk);
    reset = 1'b0;
    last_data = 8'h00;
  endtask

  task automatic test_unlock();
    logic [31:0] s;
    s = 32'hBCBCBC12;
    for (int i = 31; i >= 0; i--) begin
      send_bit(s[i]);
      tests_run++;
      if (active !== 1'b0) begin
        fails++;
        $display("FAIL unlock_active bit %0d: got %b expected 0", 32 - i, active);
      end
    end
    lock4("relock");
  endtask

  task automatic test_junk();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    tests_run++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL junk_active: got %b expected 0", active);
    end
    lock4("junk");
    push_data(8'h5A);
    send_byte(8'h5A);
    tests_run++;
    if ({valid, dout} !== {1'b1, 8'h5A}) begin
      fails++;
      $display("FAIL junk_data: got valid=%b data=%h expected 1/5a", valid, dout);
    end
  endtask

  task automatic test_n_com1();
    logic [7:0] c;
    c = 8'hBC;
    @(negedge clk);
    reset  = 1'b1;
    reset1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(c[7 - i]);
      tests_run++;
      if (active1 !== (i == 7)) begin
        fails++;
        $display("FAIL ncom1_active bit %0d: got %b expected %b", i + 1, active1, (i == 7));
      end
    end
    tests_run++;
    if ({stb1, valid1} !== 2'b10) begin
      fails++;
      $display("FAIL ncom1_lock_stb: got stb=%b valid=%b expected 1/0", stb1, valid1);
    end
    send_byte(8'hEF);
    tests_run++;
    if ({stb1, valid1, dout1} !== {2'b11, 8'hEF}) begin
      fails++;
      $display("FAIL ncom1_ef: got stb=%b valid=%b data=%h expected 1/1/ef", stb1, valid1, dout1);
    end
    send_bit(1'b0);
    tests_run++;
    if ({stb1, valid1, dout1} !== {2'b01, 8'hEF}) begin
      fails++;
      $display("FAIL ncom1_hold: got stb=%b valid=%b data=%h expected 0/1/ef", stb1, valid1, dout1);
    end
    @(negedge clk);
    reset  = 1'b0;
    reset1 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    reset1 = 1'b1;
    din = 1'b0;
    last_data = 8'h00;
    test_reset();
    test_lock();
    test_data();
    test_async_reset();
    test_unlock();
    test_junk();
    test_n_com1();
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d unconsumed bytes, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
